// File: rtl/estimador_periodo_pkg.sv
// Shared types and default constants for the period estimator.
package estimador_pkg;

  localparam int unsigned CNT_W_DFLT   = 9;
  localparam int unsigned LOG2_N_DFLT  = 3;
  localparam int unsigned CNT_MIN_DFLT = 4;
  localparam int unsigned CNT_MAX_DFLT = 500;
  localparam int unsigned TIMEOUT_DFLT = 1023;

  // Width of the accumulator and of the raw period output.
  localparam int unsigned PERIODO_W_DFLT = CNT_W_DFLT + LOG2_N_DFLT;

  typedef enum logic {
    IDLE = 1'b0,
    ACUM = 1'b1
  } estado_t;

endpackage

// File: rtl/estimador_periodo_if.sv
// Bus between the zero-crossing stage and the period estimator.
interface estimador_periodo_if
  import estimador_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DFLT,
  parameter int unsigned LOG2_N = LOG2_N_DFLT
);

  logic                    amostra_pronta;
  logic                    flag;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W+LOG2_N-1:0] periodo;
  logic                    valido;
  logic                    sem_sinal;

  modport master (
    output amostra_pronta, flag, cnt,
    input  periodo, valido, sem_sinal
  );

  modport slave (
    input  amostra_pronta, flag, cnt,
    output periodo, valido, sem_sinal
  );

endinterface

// File: rtl/estimador_periodo_detector_borda.sv
// Rising-edge detector: one event per low-to-high transition of flag.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic i_flag,
  output logic o_evento
);

  logic r_flag_d;

  // Delayed copy of flag; the event itself stays combinational so cnt is sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) r_flag_d <= 1'b0;
    else       r_flag_d <= i_flag;
  end

  assign o_evento = i_flag & ~r_flag_d;

endmodule

// File: rtl/estimador_periodo.sv
// Averages N accepted half-period counts into a fixed-point period and flags loss of signal.
module estimador_periodo
  import estimador_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DFLT,
  parameter int unsigned LOG2_N  = LOG2_N_DFLT,
  parameter int unsigned CNT_MIN = CNT_MIN_DFLT,
  parameter int unsigned CNT_MAX = CNT_MAX_DFLT,
  parameter int unsigned TIMEOUT = TIMEOUT_DFLT
) (
  input logic                clk,
  input logic                reset,
  estimador_periodo_if.slave bus
);

  localparam int unsigned PER_W = CNT_W + LOG2_N;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  estado_t           r_estado, w_estado_nxt;
  logic [PER_W-1:0]  r_acc, w_acc_nxt;
  logic [PER_W-1:0]  r_periodo, w_periodo_nxt;
  logic [LOG2_N-1:0] r_n_acc, w_n_acc_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic              r_valido, w_valido_nxt;
  logic              r_sem_sinal, w_sem_sinal_nxt;
  logic              w_evento, w_aceito, w_timeout;
  logic [PER_W-1:0]  w_soma;

  detector_borda u_detector_borda (
    .clk      (clk),
    .reset    (reset),
    .i_flag   (bus.flag),
    .o_evento (w_evento)
  );

  assign w_soma    = r_acc + {{LOG2_N{1'b0}}, bus.cnt};
  assign w_aceito  = (bus.cnt >= CNT_W'(CNT_MIN)) && (bus.cnt <= CNT_W'(CNT_MAX));
  // Fires once, on the strobe that brings the count to TIMEOUT; an event in that cycle wins.
  assign w_timeout = bus.amostra_pronta && !w_evento && (r_to_cnt == TO_LAST);

  // Strobe counter since the last crossing, saturating at TIMEOUT.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (w_evento) begin
      w_to_cnt_nxt = '0;
    end else if (bus.amostra_pronta && (r_to_cnt != TO_MAX)) begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end
  end

  // Next state for the FSM, accumulator and outputs.
  always_comb begin
    w_estado_nxt    = r_estado;
    w_acc_nxt       = r_acc;
    w_n_acc_nxt     = r_n_acc;
    w_periodo_nxt   = r_periodo;
    w_valido_nxt    = 1'b0;
    w_sem_sinal_nxt = r_sem_sinal;
    unique case (r_estado)
      IDLE: begin
        if (w_evento) begin
          // First crossing only bounds a partial interval; start clean.
          w_acc_nxt    = '0;
          w_n_acc_nxt  = '0;
          w_estado_nxt = ACUM;
        end else if (w_timeout) begin
          w_sem_sinal_nxt = 1'b1;
          w_acc_nxt       = '0;
          w_n_acc_nxt     = '0;
        end
      end
      ACUM: begin
        if (w_evento) begin
          if (!w_aceito) begin
            w_acc_nxt   = '0;
            w_n_acc_nxt = '0;
          end else if (&r_n_acc) begin
            // Nth accepted count completes the block.
            w_periodo_nxt   = w_soma;
            w_valido_nxt    = 1'b1;
            w_sem_sinal_nxt = 1'b0;
            w_acc_nxt       = '0;
            w_n_acc_nxt     = '0;
          end else begin
            w_acc_nxt   = w_soma;
            w_n_acc_nxt = r_n_acc + 1'b1;
          end
        end else if (w_timeout) begin
          w_sem_sinal_nxt = 1'b1;
          w_estado_nxt    = IDLE;
          w_acc_nxt       = '0;
          w_n_acc_nxt     = '0;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado    <= IDLE;
      r_acc       <= '0;
      r_n_acc     <= '0;
      r_to_cnt    <= '0;
      r_periodo   <= '0;
      r_valido    <= 1'b0;
      r_sem_sinal <= 1'b0;
    end else begin
      r_estado    <= w_estado_nxt;
      r_acc       <= w_acc_nxt;
      r_n_acc     <= w_n_acc_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_periodo   <= w_periodo_nxt;
      r_valido    <= w_valido_nxt;
      r_sem_sinal <= w_sem_sinal_nxt;
    end
  end

  assign bus.periodo   = r_periodo;
  assign bus.valido    = r_valido;
  assign bus.sem_sinal = r_sem_sinal;

endmodule

// File: tb/tb_estimador_periodo.sv
// Self-checking bench: queue-based reference model, directed scenarios and random traffic.
module tb_estimador_periodo;
  import estimador_pkg::*;

  localparam int unsigned NBLK = 8;
  localparam int unsigned TMO  = 1023;

  logic clk;
  logic reset;

  estimador_periodo_if #(.CNT_W(9), .LOG2_N(3)) bus ();

  estimador_periodo #(
    .CNT_W   (9),
    .LOG2_N  (3),
    .CNT_MIN (4),
    .CNT_MAX (500),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: crossings collected in a queue, silence measured in strobes.
  bit          m_ok = 1'b0;
  bit          m_prev_f;
  bit          m_primed;
  int unsigned m_q[$];
  int unsigned m_sil;
  int unsigned e_per;
  bit          e_val;
  bit          e_sem;

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1; m_prev_f = 1'b0; m_primed = 1'b0; m_q.delete();
      m_sil = 0; e_per = 0; e_val = 1'b0; e_sem = 1'b0;
    end else if (m_ok) begin
      bit ev;
      ev = bus.flag && !m_prev_f;
      m_prev_f = bus.flag;
      e_val = 1'b0;
      if (ev) begin
        m_sil = 0;
        if (!m_primed) begin
          m_primed = 1'b1;
          m_q.delete();
        end else if (bus.cnt >= 4 && bus.cnt <= 500) begin
          m_q.push_back(int'(bus.cnt));
          if (m_q.size() == NBLK) begin
            int unsigned s;
            s = 0;
            foreach (m_q[i]) s += m_q[i];
            e_per = s; e_val = 1'b1; e_sem = 1'b0;
            m_q.delete();
          end
        end else begin
          m_q.delete();
        end
      end else if (bus.amostra_pronta && m_sil < TMO) begin
        m_sil++;
        if (m_sil == TMO) begin
          e_sem = 1'b1; m_primed = 1'b0; m_q.delete();
        end
      end
    end
  end

  // Compare process plus a record of observed valid pulses.
  int unsigned n_val = 0;
  int unsigned last_per = 0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("valido", 32'(bus.valido), 32'(e_val));
      chk("sem_sinal", 32'(bus.sem_sinal), 32'(e_sem));
      chk("periodo", 32'(bus.periodo), e_per);
      if (bus.valido === 1'b1) begin
        n_val++;
        last_per = int'(bus.periodo);
      end
    end
  end

  task automatic cyc(input bit f, input logic [8:0] c, input bit s);
    bus.flag = f; bus.cnt = c; bus.amostra_pronta = s;
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd_strobe();
    return $urandom_range(0, 3) == 0;
  endfunction

  task automatic evt(input logic [8:0] c);
    cyc(1'b1, c, rnd_strobe());
    cyc(1'b0, 9'($urandom_range(0, 511)), rnd_strobe());
  endtask

  int unsigned v0;

  initial begin
    reset = 1'b1;
    bus.flag = 1'b0; bus.cnt = '0; bus.amostra_pronta = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_periodo", 32'(bus.periodo), 0);
    chk("reset_valido", 32'(bus.valido), 0);
    chk("reset_sem", 32'(bus.sem_sinal), 0);
    reset = 1'b0;

    // Steady 50: first event partial, valid after the 9th.
    v0 = n_val;
    for (int i = 0; i < 8; i++) evt(9'd50);
    chk("steady_no_early", n_val - v0, 0);
    evt(9'd50);
    chk("steady_count", n_val - v0, 1);
    chk("steady_periodo", last_per, 400);
    chk("model_pin_400", e_per, 400);

    // Jitter 49/51, then 100.
    v0 = n_val;
    for (int i = 0; i < 8; i++) evt((i % 2 == 0) ? 9'd49 : 9'd51);
    chk("jitter_periodo", last_per, 400);
    for (int i = 0; i < 8; i++) evt(9'd100);
    chk("c100_periodo", last_per, 800);
    chk("model_pin_800", e_per, 800);
    chk("jitter_count", n_val - v0, 2);

    // Glitch restarts the block.
    v0 = n_val;
    for (int i = 0; i < 5; i++) evt(9'd50);
    evt(9'd2);
    for (int i = 0; i < 7; i++) evt(9'd50);
    chk("glitch_no_early", n_val - v0, 0);
    evt(9'd50);
    chk("glitch_count", n_val - v0, 1);
    chk("glitch_periodo", last_per, 400);

    // Loss of signal.
    for (int i = 0; i < 1024; i++) cyc(1'b0, 9'd0, 1'b1);
    chk("los_sem", 32'(bus.sem_sinal), 1);
    chk("los_periodo_held", 32'(bus.periodo), 400);
    v0 = n_val;
    for (int i = 0; i < 9; i++) evt(9'd50);
    chk("los_recover_count", n_val - v0, 1);
    chk("los_recover_sem", 32'(bus.sem_sinal), 0);

    // Held flag counts once; event on the 1023rd strobe beats the timeout.
    v0 = n_val;
    for (int i = 0; i < 5; i++) cyc(1'b1, 9'd50, 1'b0);
    for (int i = 0; i < 1022; i++) cyc(1'b0, 9'd0, 1'b1);
    cyc(1'b1, 9'd50, 1'b1);
    cyc(1'b0, 9'd0, 1'b0);
    chk("coincide_sem", 32'(bus.sem_sinal), 0);
    for (int i = 0; i < 5; i++) evt(9'd50);
    chk("held_no_early", n_val - v0, 0);
    evt(9'd50);
    chk("held_count", n_val - v0, 1);
    chk("held_periodo", last_per, 400);

    // Reset mid-block.
    for (int i = 0; i < 4; i++) evt(9'd60);
    reset = 1'b1;
    cyc(1'b0, 9'd0, 1'b0);
    reset = 1'b0;
    chk("midrst_periodo", 32'(bus.periodo), 0);
    chk("midrst_valido", 32'(bus.valido), 0);
    chk("midrst_sem", 32'(bus.sem_sinal), 0);
    v0 = n_val;
    for (int i = 0; i < 8; i++) evt(9'd60);
    chk("midrst_no_early", n_val - v0, 0);
    evt(9'd60);
    chk("midrst_count", n_val - v0, 1);
    chk("midrst_periodo_new", last_per, 480);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [8:0] c;
      if ($urandom_range(0, 9) != 0) c = 9'($urandom_range(4, 500));
      else                           c = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 399) == 0) begin
        for (int k = 0; k < 1030; k++) cyc(1'b0, c, 1'b1);
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        cyc(1'b0, c, 1'b0);
        reset = 1'b0;
      end else begin
        cyc($urandom_range(0, 2) == 0, c, $urandom_range(0, 1) == 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
